mem_read_arbiter: RTL
=====================

# mem_read_arbiter

Shares the core's single AXI4 read master port between the instruction fetch unit (requester 0) and the load unit (requester 1). It grants one single-beat read at a time with load priority and a fetch starvation guard. It drives all AR-channel fields and returns the R beat to the granted requester. A fetch in flight can be cancelled by a PC redirect, and its late response is then dropped.

## Interface
Parameters:
- ADDR_W, 18, AXI byte-address width.
- STARVE_LIMIT, 4, consecutive load grants allowed while a fetch waits; the next grant then goes to fetch.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rstn  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; must hold with if_addr until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  combinational; fetch request accepted this cycle.
- if_flush  in  1  PC redirect; kills the pending or in-flight fetch response.
- if_rvalid  out  1  one-cycle pulse; if_rdata/if_rerr valid.
- if_rdata  out  32  fetched word.
- if_rerr  out  1  rresp≠0 or rid mismatch.
- ld_req, ld_addr, ld_ack, ld_rvalid, ld_rdata, ld_rerr  same as if_* for the load unit (no flush).
- araddr  out  ADDR_W.
- arburst  out  2.
- arcache  out  4.
- arid  out  4.
- arlen  out  8.
- arlock  out  1.
- arprot  out  3.
- arqos  out  4.
- arsize  out  3.
- arvalid  out  1.
- arready  in  1.
- rdata  in  32.
- rid  in  4.
- rlast  in  1.
- rready  out  1.
- rresp  in  2.
- rvalid  in  1.

## Operation
- States: IDLE, ADDR, DATA.
- IDLE:
  - Grant selection:
    - ld_req && !(if_req && starve_cnt==STARVE_LIMIT) → grant load.
    - else if_req → grant fetch.
  - Ack the grantee combinationally.
  - At the edge: latch the address into araddr and the grantee into arid (0 = fetch, 1 = load); set arvalid=1; go to ADDR.
- ADDR: on arvalid&&arready, arvalid←0, rready←1, go to DATA.
- DATA:
  - On rvalid&&rready: rready←0, go to IDLE.
  - Register rdata into the grantee's *_rdata.
  - Pulse the grantee's *_rvalid next cycle; *_rerr = (rresp≠2'b00) || (rid≠arid) || !rlast.
- Fixed AR fields: arburst=01 (INCR), arcache=0011, arlen=0, arsize=010 (4 B), arlock=0, arprot=000, arqos=0000.
- starve_cnt:
  - Increments on each load grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on any fetch grant or when if_req=0.
- Flush:
  - if_flush while the in-flight grantee is fetch (ADDR or DATA) sets kill.
  - The AR/R handshake still completes; if_rvalid is suppressed for that beat.
  - kill clears on return to IDLE.
  - if_flush in IDLE has no state effect; the requester presents its new address.
- Simultaneous if_flush and the R beat of a fetch: response suppressed.
- Simultaneous ld_req and if_req in IDLE: load wins unless starve_cnt==STARVE_LIMIT.

## Timing
- Reset values:
  - state=IDLE, arvalid=0, rready=0, araddr=0, arid=0, kill=0, starve_cnt=0.
  - All *_rvalid=0, *_rdata=0, *_rerr=0.
  - arburst=01, arcache=0011, arsize=010; other AR fields 0.
- Reset mid-transaction: state abandoned; the memory slave shares rstn.
- Latency with arready and rvalid asserted immediately:
  - ack cycle 0.
  - arvalid cycle 1.
  - rready cycle 2.
  - *_rvalid cycle 3.
- The next ack is possible in cycle 3 (IDLE), so at most one transaction per 3 cycles.
- arvalid holds until arready; rready holds until rvalid.
- Never more than one outstanding read.
- *_ack is only ever high in IDLE; at most one ack per cycle.

## Structure
- Package mem_arb_pkg holds:
  - state enum (IDLE/ADDR/DATA);
  - requester IDs ID_IF=4'd0, ID_LD=4'd1;
  - AXI constants AR_BURST_INCR, AR_CACHE_DEF, AR_SIZE_4B.
- One sub-module, arb_pick: combinational grant from ld_req, if_req and starve_cnt==STARVE_LIMIT.

## Test plan
- Single fetch, if_addr=0x00100, slave always ready, rdata=0xDEADBEEF:
  - if_ack cycle 0; araddr=0x00100 and arid=0 in cycle 1.
  - if_rvalid cycle 3 with if_rdata=0xDEADBEEF, if_rerr=0.
- ld_req and if_req held together continuously:
  - Grant order is 4 loads, 1 fetch, repeating.
  - starve_cnt resets after the fetch grant.
- Fetch in flight, if_flush pulsed while in DATA with arready delayed 2 cycles:
  - The R beat is consumed (rready handshake seen).
  - if_rvalid stays 0; the next fetch returns normally.
- Load with rresp=2'b10: ld_rvalid=1, ld_rerr=1.
- Load with rid=0 returned for arid=1: ld_rerr=1.
- arready low for 5 cycles, then rvalid low for 3 cycles:
  - arvalid and araddr stable throughout the wait; no second ack.
  - Response delivered exactly once.
- rstn low during DATA:
  - Next cycle state=IDLE, rready=0, arvalid=0.
  - The stale rvalid after reset produces no *_rvalid.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the AXI4 read-port arbiter between fetch and load.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } arb_state_t;

  localparam logic [3:0] ID_IF = 4'd0;
  localparam logic [3:0] ID_LD = 4'd1;

  localparam logic [1:0] AR_BURST_INCR = 2'b01;
  localparam logic [3:0] AR_CACHE_DEF  = 4'b0011;
  localparam logic [2:0] AR_SIZE_4B    = 3'b010;

endpackage

// File: rtl/mem_read_arbiter_arb_pick.sv
// Grant selection: load has priority unless a waiting fetch has hit the starvation limit.
module arb_pick (
  input  logic i_ld_req,
  input  logic i_if_req,
  input  logic i_starved,
  output logic o_grant_ld,
  output logic o_grant_if
);

  logic w_grant_ld;

  assign w_grant_ld = i_ld_req && !(i_if_req && i_starved);
  assign o_grant_ld = w_grant_ld;
  assign o_grant_if = i_if_req && !w_grant_ld;

endmodule

// File: rtl/mem_read_arbiter.sv
// Single-outstanding AXI4 read arbiter for fetch (ID 0) and load (ID 1) with flush-kill of fetch responses.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 18,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  input  logic              if_flush,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_rerr,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ack,
  output logic              ld_rvalid,
  output logic [31:0]       ld_rdata,
  output logic              ld_rerr,
  output logic [ADDR_W-1:0] araddr,
  output logic [1:0]        arburst,
  output logic [3:0]        arcache,
  output logic [3:0]        arid,
  output logic [7:0]        arlen,
  output logic              arlock,
  output logic [2:0]        arprot,
  output logic [3:0]        arqos,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  input  logic [31:0]       rdata,
  input  logic [3:0]        rid,
  input  logic              rlast,
  output logic              rready,
  input  logic [1:0]        rresp,
  input  logic              rvalid
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  arb_state_t        r_state;
  logic [ADDR_W-1:0] r_araddr;
  logic [3:0]        r_arid;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_kill;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_if_rvalid;
  logic [31:0]       r_if_rdata;
  logic              r_if_rerr;
  logic              r_ld_rvalid;
  logic [31:0]       r_ld_rdata;
  logic              r_ld_rerr;

  logic w_grant_ld;
  logic w_grant_if;
  logic w_starved;
  logic w_idle;
  logic w_kill_req;
  logic w_rerr;

  assign w_starved  = (r_starve_cnt == CNT_W'(STARVE_LIMIT));
  assign w_idle     = (r_state == IDLE);
  assign w_kill_req = if_flush && (r_arid == ID_IF);
  assign w_rerr     = (rresp != 2'b00) || (rid != r_arid) || !rlast;

  arb_pick u_pick (
    .i_ld_req   (ld_req),
    .i_if_req   (if_req),
    .i_starved  (w_starved),
    .o_grant_ld (w_grant_ld),
    .o_grant_if (w_grant_if)
  );

  assign if_ack = w_idle && w_grant_if;
  assign ld_ack = w_idle && w_grant_ld;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= IDLE;
      r_araddr     <= '0;
      r_arid       <= ID_IF;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_kill       <= 1'b0;
      r_starve_cnt <= '0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_if_rerr    <= 1'b0;
      r_ld_rvalid  <= 1'b0;
      r_ld_rdata   <= '0;
      r_ld_rerr    <= 1'b0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_ld_rvalid <= 1'b0;

      if (!if_req) begin
        r_starve_cnt <= '0;
      end else if (w_idle && w_grant_if) begin
        r_starve_cnt <= '0;
      end else if (w_idle && w_grant_ld && !w_starved) begin
        r_starve_cnt <= r_starve_cnt + 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_kill <= 1'b0;
          if (w_grant_ld || w_grant_if) begin
            r_araddr  <= w_grant_ld ? ld_addr : if_addr;
            r_arid    <= w_grant_ld ? ID_LD : ID_IF;
            r_arvalid <= 1'b1;
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (w_kill_req) r_kill <= 1'b1;
          if (r_arvalid && arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= DATA;
          end
        end
        DATA: begin
          if (w_kill_req) r_kill <= 1'b1;
          if (rvalid && r_rready) begin
            r_rready <= 1'b0;
            r_kill   <= 1'b0;
            r_state  <= IDLE;
            if (r_arid == ID_LD) begin
              r_ld_rvalid <= 1'b1;
              r_ld_rdata  <= rdata;
              r_ld_rerr   <= w_rerr;
            end else if (!r_kill && !if_flush) begin
              // a flush arriving with the beat itself also drops it
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= rdata;
              r_if_rerr   <= w_rerr;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign araddr    = r_araddr;
  assign arid      = r_arid;
  assign arvalid   = r_arvalid;
  assign rready    = r_rready;
  assign arburst   = AR_BURST_INCR;
  assign arcache   = AR_CACHE_DEF;
  assign arsize    = AR_SIZE_4B;
  assign arlen     = '0;
  assign arlock    = 1'b0;
  assign arprot    = '0;
  assign arqos     = '0;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign if_rerr   = r_if_rerr;
  assign ld_rvalid = r_ld_rvalid;
  assign ld_rdata  = r_ld_rdata;
  assign ld_rerr   = r_ld_rerr;

endmodule
